// File: rtl/v_pkg.sv
// v_pkg: shared command encoding and default widths for the list update
// datapath. The state word layout lives in each module because its width
// follows module parameters.
package v_pkg;

   typedef enum logic [1:0] {
      CMD_CLR = 2'd0,
      CMD_ADD = 2'd1,
      CMD_SUB = 2'd2,
      CMD_REP = 2'd3
   } cmd_t;

   localparam int V_KEY_W  = 32;
   localparam int V_SIZE_W = 16;

endpackage

// File: rtl/v_state_fwd_mux.sv
// v_state_fwd_mux: picks the freshest copy of a state entry for the compute
// stage. The write register wins over the write history, which wins over
// the RAM read data.
module v_state_fwd_mux #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 49
) (
   input  logic [ADDR_W-1:0] sel_addr,
   input  logic              s3_vld,
   input  logic [ADDR_W-1:0] s3_addr,
   input  logic [DATA_W-1:0] s3_data,
   input  logic              s4_vld,
   input  logic [ADDR_W-1:0] s4_addr,
   input  logic [DATA_W-1:0] s4_data,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] old_data
);

   // Priority match: newest in-flight write first, RAM data last
   always_comb begin
      old_data = ram_data;
      if (s3_vld && (s3_addr == sel_addr)) begin
         old_data = s3_data;
      end else if (s4_vld && (s4_addr == sel_addr)) begin
         old_data = s4_data;
      end
   end

endmodule

// File: rtl/v_state_update_pipe.sv
// v_state_update_pipe: three-stage read-modify-write pipeline applying list
// update commands to a per-product state table {vld, key, size}.
// Optional feature macro: V_STATE_UPDATE_PIPE_SAT_EN (saturating size
// arithmetic with an error pulse); without it sizes wrap and o_err_r is 0.
module v_state_update_pipe
   import v_pkg::*;
#(
   parameter int N_ID   = 16,
   parameter int KEY_W  = V_KEY_W,
   parameter int SIZE_W = V_SIZE_W,
   localparam int ADDR_W  = (N_ID > 1) ? $clog2(N_ID) : 1,
   localparam int STATE_W = 1 + KEY_W + SIZE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_upd_vld,
   input  logic [ADDR_W-1:0]  i_upd_prod_id,
   input  logic [1:0]         i_upd_cmd,
   input  logic [KEY_W-1:0]   i_upd_key,
   input  logic [SIZE_W-1:0]  i_upd_size,
   output logic               o_state_ren,
   output logic [ADDR_W-1:0]  o_state_raddr,
   input  logic [STATE_W-1:0] i_state_rdata,
   output logic               o_state_wen_r,
   output logic [ADDR_W-1:0]  o_state_waddr_r,
   output logic [STATE_W-1:0] o_state_wdata_r,
   output logic               o_err_r
);

   localparam logic [ADDR_W:0] ID_LIMIT = (ADDR_W+1)'(N_ID);

   logic               s1_vld;
   logic [ADDR_W-1:0]  s1_prod_id;
   cmd_t               s1_cmd;
   logic [KEY_W-1:0]   s1_key;
   logic [SIZE_W-1:0]  s1_size;

   logic               s2_vld;
   logic [ADDR_W-1:0]  s2_prod_id;
   cmd_t               s2_cmd;
   logic [KEY_W-1:0]   s2_key;
   logic [SIZE_W-1:0]  s2_size;

   logic               s4_vld;
   logic [ADDR_W-1:0]  s4_addr;
   logic [STATE_W-1:0] s4_data;

   logic [STATE_W-1:0] old_state;
   logic               old_vld;
   logic [KEY_W-1:0]   old_key;
   logic [SIZE_W-1:0]  old_size;
   logic [STATE_W-1:0] new_state;
   logic               wen_c;
`ifdef V_STATE_UPDATE_PIPE_SAT_EN
   logic               err_c;
   logic [SIZE_W:0]    sum_w;
`endif

   // S1 control: valid bit and read address, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld     <= 1'b0;
         s1_prod_id <= '0;
      end else begin
         s1_vld <= i_upd_vld;
         if (i_upd_vld) begin
            s1_prod_id <= i_upd_prod_id;
         end
      end
   end

   // S1 payload capture, no reset needed
   always_ff @(posedge clk) begin
      if (i_upd_vld) begin
         s1_cmd  <= cmd_t'(i_upd_cmd);
         s1_key  <= i_upd_key;
         s1_size <= i_upd_size;
      end
   end

   // Out-of-range products never issue a read and never reach S2
   always_comb begin
      o_state_ren   = s1_vld && ({1'b0, s1_prod_id} < ID_LIMIT);
      o_state_raddr = s1_prod_id;
   end

   // S2 valid follows the read enable so dropped commands vanish here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
      end else begin
         s2_vld <= o_state_ren;
      end
   end

   // S2 payload capture alongside the RAM read
   always_ff @(posedge clk) begin
      if (o_state_ren) begin
         s2_prod_id <= s1_prod_id;
         s2_cmd     <= s1_cmd;
         s2_key     <= s1_key;
         s2_size    <= s1_size;
      end
   end

   v_state_fwd_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (STATE_W)
   ) u_fwd_mux (
      .sel_addr (s2_prod_id),
      .s3_vld   (o_state_wen_r),
      .s3_addr  (o_state_waddr_r),
      .s3_data  (o_state_wdata_r),
      .s4_vld   (s4_vld),
      .s4_addr  (s4_addr),
      .s4_data  (s4_data),
      .ram_data (i_state_rdata),
      .old_data (old_state)
   );

   // Compute the new state word from the forwarded old state and command
   always_comb begin
      old_vld   = old_state[STATE_W-1];
      old_key   = old_state[SIZE_W +: KEY_W];
      old_size  = old_state[SIZE_W-1:0];
      new_state = '0;
      wen_c     = 1'b0;
`ifdef V_STATE_UPDATE_PIPE_SAT_EN
      err_c     = 1'b0;
      sum_w     = {1'b0, old_size} + {1'b0, s2_size};
`endif
      case (s2_cmd)
         CMD_CLR: begin
            wen_c = 1'b1;
         end
         CMD_ADD: begin
            wen_c = 1'b1;
            if (!old_vld) begin
               new_state = {1'b1, s2_key, s2_size};
            end else begin
`ifdef V_STATE_UPDATE_PIPE_SAT_EN
               if (sum_w[SIZE_W]) begin
                  new_state = {1'b1, old_key, {SIZE_W{1'b1}}};
                  err_c     = 1'b1;
               end else begin
                  new_state = {1'b1, old_key, sum_w[SIZE_W-1:0]};
               end
`else
               new_state = {1'b1, old_key, old_size + s2_size};
`endif
            end
         end
         CMD_SUB: begin
            if (old_vld) begin
               wen_c = 1'b1;
`ifdef V_STATE_UPDATE_PIPE_SAT_EN
               if (s2_size > old_size) begin
                  err_c = 1'b1;
               end else if (old_size != s2_size) begin
                  new_state = {1'b1, old_key, old_size - s2_size};
               end
`else
               if (old_size != s2_size) begin
                  new_state = {1'b1, old_key, old_size - s2_size};
               end
`endif
            end
`ifdef V_STATE_UPDATE_PIPE_SAT_EN
            else begin
               err_c = 1'b1;
            end
`endif
         end
         CMD_REP: begin
            wen_c     = 1'b1;
            new_state = {1'b1, s2_key, s2_size};
         end
         default: begin
            wen_c = 1'b0;
         end
      endcase
   end

   // S3 write register drives the RAM and is the first forwarding source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_state_wen_r   <= 1'b0;
         o_state_waddr_r <= '0;
         o_state_wdata_r <= '0;
      end else begin
         o_state_wen_r <= s2_vld && wen_c;
         if (s2_vld && wen_c) begin
            o_state_waddr_r <= s2_prod_id;
            o_state_wdata_r <= new_state;
         end
      end
   end

`ifdef V_STATE_UPDATE_PIPE_SAT_EN
   // Arithmetic error pulse, aligned with the write it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_err_r <= 1'b0;
      end else begin
         o_err_r <= s2_vld && err_c;
      end
   end
`else
   assign o_err_r = 1'b0;
`endif

   // S4 valid: remembers that the previous cycle carried a RAM write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s4_vld <= 1'b0;
      end else begin
         s4_vld <= o_state_wen_r;
      end
   end

   // S4 payload covers the write not yet visible to the current read
   always_ff @(posedge clk) begin
      if (o_state_wen_r) begin
         s4_addr <= o_state_waddr_r;
         s4_data <= o_state_wdata_r;
      end
   end

endmodule
